// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access unit: access-size codes,
// FSM state encoding and the default bus wait limit.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } stateT;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the pipeline and the 32-bit bus: byte enables,
// store-data replication, load lane extraction/extension and misalignment.
module mem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addrLow,
  input  logic        isUnsigned,
  input  logic [31:0] storeData,
  input  logic [31:0] readWord,
  output logic [3:0]  byteEn,
  output logic [31:0] laneData,
  output logic [31:0] loadData,
  output logic        misaligned
);

  logic [7:0]  selByte;
  logic [15:0] selHalf;

  // Select the addressed byte and half-word lanes from the read word.
  always_comb begin
    selByte = readWord[7:0];
    case (addrLow)
      2'b00: selByte = readWord[7:0];
      2'b01: selByte = readWord[15:8];
      2'b10: selByte = readWord[23:16];
      2'b11: selByte = readWord[31:24];
      default: selByte = readWord[7:0];
    endcase
    selHalf = addrLow[1] ? readWord[31:16] : readWord[15:0];
  end

  // Per-size enables, replicated store data, extended load data and alignment check; size 11 acts as word.
  always_comb begin
    byteEn     = 4'b1111;
    laneData   = storeData;
    loadData   = readWord;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        byteEn   = 4'b0001 << addrLow;
        laneData = {4{storeData[7:0]}};
        loadData = isUnsigned ? {24'h000000, selByte} : {{24{selByte[7]}}, selByte};
      end
      SZ_HALF: begin
        byteEn     = addrLow[1] ? 4'b1100 : 4'b0011;
        laneData   = {2{storeData[15:0]}};
        loadData   = isUnsigned ? {16'h0000, selHalf} : {{16{selHalf[15]}}, selHalf};
        misaligned = addrLow[0];
      end
      default: begin
        byteEn     = 4'b1111;
        laneData   = storeData;
        loadData   = readWord;
        misaligned = (addrLow != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/dmem_access.sv
// Data-memory access unit: turns a memory-stage load/store into a held bus
// transaction, stalls the pipeline until ack (or timeout) and returns the
// extended load data for writeback.
module dmem_access
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        addr_err_o,
  output logic        timeout_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT);

  stateT       state;
  logic [7:0]  waitCount;
  logic [1:0]  reqSize;
  logic [1:0]  reqAddrLow;
  logic        reqUnsigned;

  logic [1:0]  alignSize;
  logic [1:0]  alignAddrLow;
  logic        alignUnsigned;
  logic [3:0]  byteEn;
  logic [31:0] laneData;
  logic [31:0] loadData;
  logic        misaligned;
  logic        issue;

  // Lane logic looks at the live request while idle and at the latched one while the bus is busy.
  always_comb begin
    alignSize     = (state == IDLE) ? mem_size_i     : reqSize;
    alignAddrLow  = (state == IDLE) ? addr_i[1:0]    : reqAddrLow;
    alignUnsigned = (state == IDLE) ? mem_unsigned_i : reqUnsigned;
  end

  mem_lane_align laneAlign (
    .size       (alignSize),
    .addrLow    (alignAddrLow),
    .isUnsigned (alignUnsigned),
    .storeData  (wdata_i),
    .readWord   (bus_rdata_i),
    .byteEn     (byteEn),
    .laneData   (laneData),
    .loadData   (loadData),
    .misaligned (misaligned)
  );

  // Issue decision, error flag and stall are combinational so the issuing cycle is already frozen.
  always_comb begin
    issue      = (state == IDLE) && mem_valid_i && !misaligned;
    addr_err_o = (state == IDLE) && mem_valid_i && misaligned;
    stall_o    = issue || (state == REQ);
  end

  // FSM with registered bus fields, wait counter, load data and timeout pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      waitCount   <= 8'd0;
      reqSize     <= SZ_BYTE;
      reqAddrLow  <= 2'b00;
      reqUnsigned <= 1'b0;
      rdata_o     <= 32'd0;
      timeout_o   <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'd0;
      bus_be_o    <= 4'd0;
      bus_wdata_o <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          timeout_o <= 1'b0;
          if (issue) begin
            state       <= REQ;
            waitCount   <= 8'd0;
            reqSize     <= mem_size_i;
            reqAddrLow  <= addr_i[1:0];
            reqUnsigned <= mem_unsigned_i;
            rdata_o     <= 32'd0;
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= {addr_i[31:2], 2'b00};
            bus_be_o    <= byteEn;
            bus_wdata_o <= laneData;
          end
        end
        REQ: begin
          if (bus_ack_i) begin
            state     <= DONE;
            bus_req_o <= 1'b0;
            bus_we_o  <= 1'b0;
            rdata_o   <= bus_we_o ? 32'd0 : loadData;
          end else if (waitCount == TimeoutLimit - 8'd1) begin
            state     <= DONE;
            waitCount <= waitCount + 8'd1;
            bus_req_o <= 1'b0;
            bus_we_o  <= 1'b0;
            rdata_o   <= 32'd0;
            timeout_o <= 1'b1;
          end else begin
            waitCount <= waitCount + 8'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          timeout_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access.sv
// Directed self-checking bench for dmem_access, built with a short wait limit
// so the abandon path is reachable quickly.
module tb_dmem_access;

  logic        clk;
  logic        rst;
  logic        mem_valid_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic        mem_unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        addr_err_o;
  logic        timeout_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  int testsRun;
  int testsFailed;

  logic [31:0] obsRdata;
  logic        obsTimeout;
  int          stallCycles;
  logic [3:0]  obsBe;
  logic [31:0] obsBusAddr;
  logic [31:0] obsBusWdata;
  logic        obsBusWe;

  dmem_access #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid_i    (mem_valid_i),
    .mem_we_i       (mem_we_i),
    .mem_size_i     (mem_size_i),
    .mem_unsigned_i (mem_unsigned_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .rdata_o        (rdata_o),
    .stall_o        (stall_o),
    .addr_err_o     (addr_err_o),
    .timeout_o      (timeout_o),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_be_o       (bus_be_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_ack_i      (bus_ack_i),
    .bus_rdata_i    (bus_rdata_i)
  );

  // Free-running pipeline clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one memory-stage op from a falling edge and plays the bus: ack on REQ cycle index ackDelay.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdWord, input int ackDelay);
    int reqCycles;
    int budget;
    bit captured;
    reqCycles   = 0;
    budget      = 0;
    captured    = 0;
    stallCycles = 0;
    obsBe       = 4'd0;
    obsBusAddr  = 32'd0;
    obsBusWdata = 32'd0;
    obsBusWe    = 1'b0;
    @(negedge clk);
    mem_valid_i    = 1'b1;
    mem_we_i       = we;
    mem_size_i     = size;
    mem_unsigned_i = uns;
    addr_i         = addr;
    wdata_i        = wdata;
    bus_rdata_i    = rdWord;
    bus_ack_i      = 1'b0;
    #1;
    while (stall_o && budget < 300) begin
      if (bus_req_o) begin
        if (!captured) begin
          obsBe       = bus_be_o;
          obsBusAddr  = bus_addr_o;
          obsBusWdata = bus_wdata_o;
          obsBusWe    = bus_we_o;
          captured    = 1;
        end
        bus_ack_i = (reqCycles == ackDelay);
        reqCycles++;
      end else begin
        bus_ack_i = 1'b0;
      end
      stallCycles++;
      @(negedge clk);
      #1;
      budget++;
    end
    if (budget >= 300) checkOutput("stallBound", 32'd1, 32'd0);
    obsRdata    = rdata_o;
    obsTimeout  = timeout_o;
    bus_ack_i   = 1'b0;
    mem_valid_i = 1'b0;
  endtask

  // Runs one access and compares every observable against hand-computed values.
  task automatic checkAccess(input string name, input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdWord,
                             input int ackDelay, input logic [3:0] expBe, input logic [31:0] expWdata,
                             input logic [31:0] expRdata, input logic expTimeout, input int expStall);
    applyStimulus(we, size, uns, addr, wdata, rdWord, ackDelay);
    checkOutput($sformatf("%s.be", name), {28'd0, obsBe}, {28'd0, expBe});
    checkOutput($sformatf("%s.addr", name), obsBusAddr, {addr[31:2], 2'b00});
    checkOutput($sformatf("%s.we", name), {31'd0, obsBusWe}, {31'd0, we});
    if (we) checkOutput($sformatf("%s.wdata", name), obsBusWdata, expWdata);
    checkOutput($sformatf("%s.rdata", name), obsRdata, expRdata);
    checkOutput($sformatf("%s.timeout", name), {31'd0, obsTimeout}, {31'd0, expTimeout});
    checkOutput($sformatf("%s.stall", name), stallCycles, expStall);
  endtask

  initial begin
    testsRun       = 0;
    testsFailed    = 0;
    rst            = 1'b0;
    mem_valid_i    = 1'b0;
    mem_we_i       = 1'b0;
    mem_size_i     = 2'b00;
    mem_unsigned_i = 1'b0;
    addr_i         = 32'd0;
    wdata_i        = 32'd0;
    bus_ack_i      = 1'b0;
    bus_rdata_i    = 32'd0;

    #12;
    checkOutput("rst.stall", {31'd0, stall_o}, 32'd0);
    checkOutput("rst.req", {31'd0, bus_req_o}, 32'd0);
    checkOutput("rst.we", {31'd0, bus_we_o}, 32'd0);
    checkOutput("rst.be", {28'd0, bus_be_o}, 32'd0);
    checkOutput("rst.addr", bus_addr_o, 32'd0);
    checkOutput("rst.wdata", bus_wdata_o, 32'd0);
    checkOutput("rst.rdata", rdata_o, 32'd0);
    checkOutput("rst.timeout", {31'd0, timeout_o}, 32'd0);
    checkOutput("rst.addrErr", {31'd0, addr_err_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    checkAccess("sw",    1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    checkAccess("sb",    1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00A5, 32'h0, 1, 4'b1000, 32'hA5A5_A5A5, 32'h0, 1'b0, 3);
    checkAccess("sh",    1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h1234_BEEF, 32'h0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0, 2);
    checkAccess("lb",    1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0, 32'h1280_3456, 0, 4'b0100, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
    checkAccess("lbu",   1'b0, 2'b00, 1'b1, 32'h0000_0102, 32'h0, 32'h1280_3456, 0, 4'b0100, 32'h0, 32'h0000_0080, 1'b0, 2);
    checkAccess("lb3",   1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h1280_3456, 2, 4'b1000, 32'h0, 32'h0000_0012, 1'b0, 4);
    checkAccess("lh",    1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 0, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b0, 2);
    checkAccess("lhu",   1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 0, 4'b1100, 32'h0, 32'h0000_8001, 1'b0, 2);
    checkAccess("lhLow", 1'b0, 2'b01, 1'b0, 32'h0000_0200, 32'h0, 32'h8001_7FFF, 0, 4'b0011, 32'h0, 32'h0000_7FFF, 1'b0, 2);
    checkAccess("lwSz3", 1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 0, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0, 2);
    checkAccess("ackAtLimit", 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'h1357_9BDF, 3, 4'b1111, 32'h0, 32'h1357_9BDF, 1'b0, 5);
    checkAccess("timeout", 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'hFFFF_FFFF, 1000, 4'b1111, 32'h0, 32'h0, 1'b1, 5);
    @(negedge clk);
    #1;
    checkOutput("timeoutCleared", {31'd0, timeout_o}, 32'd0);

    // Misaligned word load: error flag, no stall, no bus request.
    @(negedge clk);
    mem_valid_i = 1'b1;
    mem_we_i    = 1'b0;
    mem_size_i  = 2'b10;
    addr_i      = 32'h0000_0006;
    #1;
    checkOutput("misalign.err", {31'd0, addr_err_o}, 32'd1);
    checkOutput("misalign.stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("misalign.req", {31'd0, bus_req_o}, 32'd0);
    mem_size_i = 2'b00;
    #1;
    checkOutput("byteNeverMisaligned", {31'd0, addr_err_o}, 32'd0);
    mem_valid_i = 1'b0;

    // Reset mid-transaction drops the request at once; the next load issues normally.
    @(negedge clk);
    mem_valid_i = 1'b1;
    mem_size_i  = 2'b10;
    addr_i      = 32'h0000_0500;
    @(negedge clk);
    #1;
    checkOutput("preRst.req", {31'd0, bus_req_o}, 32'd1);
    mem_valid_i = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midRst.req", {31'd0, bus_req_o}, 32'd0);
    checkOutput("midRst.stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    checkAccess("postRst", 1'b0, 2'b10, 1'b0, 32'h0000_0504, 32'h0, 32'h2468_ACE0, 0, 4'b1111, 32'h0, 32'h2468_ACE0, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/dmem_access.md
# dmem_access

Data-memory access unit between the memory stage of the five-stage MIPS pipeline and a variable-latency data bus. It takes the memory-stage request: address from the ALU result, store data, write flag, size and signedness. It generates the word-aligned bus transaction with byte enables and holds it until the bus acknowledges. It returns the lane-aligned, sign/zero-extended load data to the writeback register. While a transaction is outstanding it stalls the whole pipeline through the hazard unit.

## Interface
Parameters:
- TIMEOUT, 255: max cycles a request waits for ack before it is abandoned (1..255).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; one clock, no other reset.
- mem_valid_i  in  1  memory-stage instruction is a load or store.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_size_i  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- mem_unsigned_i  in  1  load zero-extends (lbu/lhu) when 1, sign-extends when 0.
- addr_i  in  32  byte address (ALUOutM).
- wdata_i  in  32  store data (WriteDataM), value in low bits.
- rdata_o  out  32  extended load data; valid in DONE.
- stall_o  out  1  freeze F/D/E/M pipeline registers.
- addr_err_o  out  1  misaligned access, no bus traffic.
- timeout_o  out  1  one-cycle pulse in DONE when the request timed out.
- bus_req_o  out  1  request held high until ack.
- bus_we_o  out  1  write request.
- bus_addr_o  out  32  {addr_i[31:2], 2'b00}.
- bus_be_o  out  4  byte enables.
- bus_wdata_o  out  32  lane-replicated store data.
- bus_ack_i  in  1  transfer complete; bus_rdata_i valid same cycle.
- bus_rdata_i  in  32  read word.

## Operation
- States: IDLE, REQ, DONE.
- IDLE: if mem_valid_i and aligned -> latch bus fields, go REQ. If misaligned -> stay IDLE.
- REQ: bus_req_o=1, fields stable. On bus_ack_i -> latch extended read data, go DONE. If wait counter reaches TIMEOUT -> rdata 0, set timeout flag, go DONE.
- DONE: go IDLE unconditionally. The same instruction is still on mem_valid_i this cycle and is never reissued.
- Misalignment: half with addr[0]=1; word with addr[1:0]≠00. Byte is never misaligned.
- Byte enables:
  - byte: 4'b0001<<addr[1:0].
  - half: addr[1] ? 1100 : 0011.
  - word: 1111.
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: unchanged.
- Load extract: lane selected by addr[1:0] (byte) or addr[1] (half), then extended per mem_unsigned_i to 32 bits. Word loads pass through.
- Write acks latch no data; rdata_o reads 0 in DONE for stores.
- Wait counter: 8 bits, cleared on entry to REQ, increments each REQ cycle without ack.

## Timing
- Reset values: state IDLE, stall_o 0, bus_req_o 0, bus_we_o 0, bus_be_o 0, bus_addr_o 0, bus_wdata_o 0, rdata_o 0, timeout_o 0, addr_err_o 0, counter 0.
- Reset asserted mid-REQ: bus_req_o drops immediately (asynchronous); the transaction is abandoned.
- stall_o = (IDLE & mem_valid_i & aligned) | REQ. This is combinational, so the issuing cycle is already stalled. In DONE stall_o is 0, so the pipeline advances on that edge.
- Minimum latency: op enters M at cycle 0, bus_req_o high at cycle 1. If ack arrives in cycle 1, DONE is cycle 2. That gives 2 stall cycles; each extra wait cycle adds one.
- bus_ack_i is ignored outside REQ.
- Ack in the same cycle the counter hits TIMEOUT: ack wins, no timeout.
- addr_err_o is combinational, asserted only in IDLE with mem_valid_i; no stall, no bus_req_o.
- rdata_o and timeout_o are registered; they are stable only in DONE, and timeout_o clears on leaving DONE.

## Structure
- Shared package `dmem_pkg`: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, default TIMEOUT.
- One combinational sub-module `mem_lane_align`: byte-enable generation, store replication, load extraction and extension, misalignment detect.
- FSM, counter and bus registers stay in `dmem_access`.

## Test plan
- sw addr 0x0000_0104, wdata 0xDEADBEEF, ack in cycle 1 -> bus_be_o 1111, bus_addr_o 0x104, bus_wdata_o 0xDEADBEEF, stall_o high cycles 0–1, low in cycle 2.
- sb addr 0x0000_0013, wdata 0x0000_00A5 -> bus_be_o 1000, bus_wdata_o 0xA5A5A5A5.
- lb addr 0x...02 with bus_rdata 0x1280_3456 -> rdata_o 0xFFFFFF80; the same access as lbu -> 0x0000_0080.
- lh addr 0x...02 with bus_rdata 0x8001_7FFF -> rdata_o 0xFFFF8001.
- lw addr 0x...06 -> addr_err_o 1 that cycle, bus_req_o stays 0, stall_o 0.
- Timeout: TIMEOUT=4, no ack -> DONE after 4 REQ cycles, timeout_o pulse, rdata_o 0.
- Reset during REQ: bus_req_o 0 immediately, state IDLE after release, next lw issues normally.
